multicycle_processor: RTL
=========================

MULTICYCLE_PROCESSOR -- requirements
Module: multicycle_processor

Interface
REQ-001 SHALL have parameter DATA_W, default 32: datapath and register width; legal range 16..64.
REQ-002 SHALL have parameter NREG, default 32: register count, power of two, max 32.
REQ-003 SHALL have parameter DMEM_DEPTH, default 64: data-memory words, power of two.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port Inst  input  32  instruction word; opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm16 [15:0].
REQ-007 SHALL have port inst_valid  input  1  Inst holds a valid instruction.
REQ-008 SHALL have port inst_ready  output  1  core accepts an instruction this cycle.
REQ-009 SHALL have port WD  output  DATA_W  register write-back data.
REQ-010 SHALL have port wd_valid  output  1  WD is being written this cycle.
REQ-011 SHALL have port isZero  output  1  last ALU result was zero.
REQ-012 SHALL have port illegal  output  1  one-cycle pulse on an unknown opcode.

Function
REQ-013 SHALL decode opcodes: add 000001, lw 000010, sub 000011, sw 000100, and 000101, or 000110, slt 000111 (signed); funct field ignored.
REQ-014 SHALL implement FSM states IDLE, DECODE, EXEC, MEM, WB.
REQ-015 SHALL assert inst_ready only in IDLE; handshake completes on inst_valid && inst_ready, latching Inst into an instruction register and moving to DECODE.
REQ-016 SHALL ignore Inst changes after acceptance.
REQ-017 SHALL in DECODE latch rs/rt operands from the register file.
REQ-018 SHALL in DECODE, on an unknown opcode, pulse illegal for one cycle, return to IDLE, and write no register or memory.
REQ-019 SHALL in EXEC register the ALU result and set isZero = (result == 0).
REQ-020 SHALL hold isZero between instructions.
REQ-021 SHALL route R-type (add/sub/and/or/slt) EXEC -> WB, writing rd.
REQ-022 SHALL compute lw/sw address = rs + sign-extended imm16, word-addressed, taken modulo DMEM_DEPTH (wrap-around).
REQ-023 SHALL route lw EXEC -> MEM (synchronous read) -> WB, writing rt.
REQ-024 SHALL route sw EXEC -> MEM (write rt data) -> IDLE, with no write-back.
REQ-025 SHALL drive wd_valid = 1 and WD = write data only in WB; WD holds its last value otherwise.
REQ-026 SHALL give latency from the accept edge: R-type WB in the 3rd cycle, lw WB in the 4th; next inst_ready 1 cycle after WB (or after MEM for sw).
REQ-027 SHALL perform arithmetic modulo 2^DATA_W with no overflow flag.
REQ-028 SHALL use only log2(NREG) low bits of register fields.
REQ-029 SHALL read register 0 as zero and discard writes to it (wd_valid still asserts).
REQ-030 SHALL, when WB and an R-type write target the same register as a later read, return the written value to the later instruction; no overlap of instructions is possible.

Reset
REQ-031 SHALL, on reset low, immediately force the FSM to IDLE.
REQ-032 SHALL reset outputs to inst_ready=1, wd_valid=0, WD=0, isZero=0, illegal=0.
REQ-033 SHALL reset register i to value i (reg0 = 0) and all data memory to 0.
REQ-034 SHALL abandon an instruction when reset is asserted mid-operation, writing no register or memory.

Structure
REQ-035 SHALL place opcode constants, FSM state encoding and ALU-op encoding in shared package processor_pkg.
REQ-036 SHALL use one combinational sub-module, alu_unit (DATA_W-parameterised: add/sub/and/or/slt, zero output).
REQ-037 SHALL keep the register file and data memory inline.

Verification
REQ-038 SHALL cover: after reset, add rd=1, rs=2, rt=3 accepted -> 3rd cycle wd_valid=1, WD=5, isZero=0; r1=5.
REQ-039 SHALL cover: sub rs=2, rt=3 -> WD=0xFFFFFFFF (DATA_W=32), isZero=0; sub rs=2, rt=2 -> WD=0, isZero=1.
REQ-040 SHALL cover: sw rt=5, rs=2, imm=-1 writes dmem[1]=5, no wd_valid; then lw rt=7, rs=0, imm=1 -> 4th cycle WD=5, r7=5; imm=65 aliases dmem[1] (DEPTH=64).
REQ-041 SHALL cover: opcode 111111 -> illegal pulses 1 cycle after accept, inst_ready returns the next cycle, registers unchanged.
REQ-042 SHALL cover: reset asserted during EXEC of add rd=1 -> inst_ready=1 immediately, r1 reads 1 afterwards.
REQ-043 SHALL cover: add rd=0 -> wd_valid=1, subsequent read of r0 = 0; inst_valid held low keeps FSM in IDLE.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared definitions for the multicycle processor: opcode constants, FSM
// state encoding, ALU operation encoding and small decode helpers.
package processor_pkg;

  localparam logic [5:0] OP_ADD = 6'b000001;
  localparam logic [5:0] OP_LW  = 6'b000010;
  localparam logic [5:0] OP_SUB = 6'b000011;
  localparam logic [5:0] OP_SW  = 6'b000100;
  localparam logic [5:0] OP_AND = 6'b000101;
  localparam logic [5:0] OP_OR  = 6'b000110;
  localparam logic [5:0] OP_SLT = 6'b000111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_LW) || (op == OP_SUB) || (op == OP_SW) ||
           (op == OP_AND) || (op == OP_OR) || (op == OP_SLT);
  endfunction

  function automatic logic op_is_mem(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  // lw/sw fall through to ALU_ADD for address generation.
  function automatic alu_op_t op_to_alu(input logic [5:0] op);
    alu_op_t r;
    case (op)
      OP_SUB:  r = ALU_SUB;
      OP_AND:  r = ALU_AND;
      OP_OR:   r = ALU_OR;
      OP_SLT:  r = ALU_SLT;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_unit.sv
// Combinational ALU for the multicycle processor.
//   op   : operation select (add/sub/and/or/signed slt)
//   a, b : operands
//   y    : result, modulo 2^DATA_W
//   zero : y == 0
module alu_unit
  import processor_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              zero
);

  always_comb begin
    y = '0;
    unique case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y[0] = $signed(a) < $signed(b);
      default: y = '0;
    endcase
    zero = (y == '0);
  end

endmodule

// File: rtl/multicycle_processor.sv
// Multicycle processor core: IDLE -> DECODE -> EXEC -> (MEM) -> WB.
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low
//   Inst       : instruction word, accepted on inst_valid && inst_ready
//   inst_valid : Inst is valid
//   inst_ready : core is idle and accepts an instruction
//   WD         : write-back data (held between write-backs)
//   wd_valid   : WD is being written this cycle (WB state)
//   isZero     : last ALU result was zero (held between instructions)
//   illegal    : one-cycle pulse, during DECODE, for an unknown opcode
module multicycle_processor
  import processor_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NREG       = 32,
  parameter int DMEM_DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       Inst,
  input  logic              inst_valid,
  output logic              inst_ready,
  output logic [DATA_W-1:0] WD,
  output logic              wd_valid,
  output logic              isZero,
  output logic              illegal
);

  localparam int RW = $clog2(NREG);
  localparam int AW = $clog2(DMEM_DEPTH);

  state_t            state;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a_reg, b_reg;
  logic [AW-1:0]     mem_addr;
  logic [RW-1:0]     wb_dest;
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];

  logic [5:0]        opcode;
  logic [RW-1:0]     rs, rt, rd;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] alu_b, alu_y;
  logic              alu_zero;
  alu_op_t           alu_op;

  assign opcode  = ir[31:26];
  assign rs      = ir[21 +: RW];
  assign rt      = ir[16 +: RW];
  assign rd      = ir[11 +: RW];
  assign imm_ext = DATA_W'($signed(ir[15:0]));
  assign alu_op  = op_to_alu(opcode);
  assign alu_b   = op_is_mem(opcode) ? imm_ext : b_reg;

  alu_unit #(.DATA_W(DATA_W)) u_alu (
    .op   (alu_op),
    .a    (a_reg),
    .b    (alu_b),
    .y    (alu_y),
    .zero (alu_zero)
  );

  // Register-file and memory writes happen on the edge leaving WB/MEM, so an
  // instruction abandoned by reset never commits any state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      inst_ready <= 1'b1;
      wd_valid   <= 1'b0;
      WD         <= '0;
      isZero     <= 1'b0;
      illegal    <= 1'b0;
      ir         <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      mem_addr   <= '0;
      wb_dest    <= '0;
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= DATA_W'(i);
      for (int unsigned j = 0; j < DMEM_DEPTH; j++) dmem[j] <= '0;
    end else begin
      illegal  <= 1'b0;
      wd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (inst_valid) begin
            ir         <= Inst;
            inst_ready <= 1'b0;
            // Flag decoded at accept so the pulse coincides with DECODE.
            illegal    <= !op_legal(Inst[31:26]);
            state      <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!op_legal(opcode)) begin
            inst_ready <= 1'b1;
            state      <= S_IDLE;
          end else begin
            a_reg <= regs[rs];
            b_reg <= regs[rt];
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          isZero <= alu_zero;
          if (op_is_mem(opcode)) begin
            mem_addr <= alu_y[AW-1:0];
            state    <= S_MEM;
          end else begin
            WD       <= alu_y;
            wd_valid <= 1'b1;
            wb_dest  <= rd;
            state    <= S_WB;
          end
        end
        S_MEM: begin
          if (opcode == OP_LW) begin
            WD       <= dmem[mem_addr];
            wd_valid <= 1'b1;
            wb_dest  <= rt;
            state    <= S_WB;
          end else begin
            dmem[mem_addr] <= b_reg;
            inst_ready     <= 1'b1;
            state          <= S_IDLE;
          end
        end
        S_WB: begin
          if (wb_dest != '0) regs[wb_dest] <= WD;
          inst_ready <= 1'b1;
          state      <= S_IDLE;
        end
        default: begin
          inst_ready <= 1'b1;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
